eth_frame_rx_v2: RTL and testbench

- Parametrised successor to the single-port Ethernet byte receiver.
- Parses an octet stream: preamble, SFD, destination MAC, source MAC, length, payload, FCS. The input carries a per-byte valid qualifier, so the upstream source may stall.
- Streams payload bytes out with start/end markers and a registered per-frame status.
- Adds broadcast/promiscuous address filtering, a length bound, a stall timeout and saturating frame counters.
- Sits between the PHY byte interface and the packet buffer.

---
 rtl/eth_frame_rx_v2.sv | 227 ++++++++++++++++++++++
 tb/tb_eth_frame_rx_v2.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_rx_v2.sv
// Ethernet octet-stream receiver: preamble/SFD/address/length parsing, payload
// streaming with sof/eof, LRC-based FCS check, stall timeout and frame statistics.
module eth_frame_rx_v2 #(
    parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
    parameter int          PREAMBLE_LEN  = 7,
    parameter int          FCS_LEN       = 4,
    parameter int          MAX_PAYLOAD   = 1500,
    parameter bit          ACCEPT_BCAST  = 1'b1,
    parameter int          TIMEOUT       = 255,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_data,
    input  logic             i_data_vld,
    input  logic             i_start,
    input  logic             i_promisc,
    output logic             o_ready,
    output logic [7:0]       o_pl_data,
    output logic             o_pl_vld,
    output logic             o_pl_sof,
    output logic             o_pl_eof,
    output logic [47:0]      o_src_mac,
    output logic             o_done,
    output logic [2:0]       o_status,
    output logic [CNT_W-1:0] o_ok_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, SFD, MACDST, MACSRC, LEN, PL, FCS, DONE
    } state_t;

    localparam logic [2:0] ST_OK   = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DROP = 3'd3;
    localparam logic [2:0] ST_LEN  = 3'd4;
    localparam logic [2:0] ST_FCS  = 3'd5;
    localparam logic [2:0] ST_TO   = 3'd6;

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] FCS_LAST = 16'(FCS_LEN - 1);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam int          TO_W     = $clog2(TIMEOUT + 2);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    function automatic logic [7:0] dest_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return DEST_MAC_ADDR[47:40];
            3'd1:    return DEST_MAC_ADDR[39:32];
            3'd2:    return DEST_MAC_ADDR[31:24];
            3'd3:    return DEST_MAC_ADDR[23:16];
            3'd4:    return DEST_MAC_ADDR[15:8];
            default: return DEST_MAC_ADDR[7:0];
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [2:0]       w_status_nxt;
    logic [15:0]      r_cnt;
    logic [TO_W-1:0]  r_idle;
    logic [7:0]       r_lrc;
    logic             r_dst_ok, r_dst_bc;
    logic [47:0]      r_src_hold;
    logic [15:0]      r_len;
    logic [7:0]       r_pl_data_p1;
    logic             r_pl_vld_p1, r_pl_sof_p1, r_pl_eof_p1;
    logic [47:0]      r_src_mac;
    logic [2:0]       r_status;
    logic [CNT_W-1:0] r_ok_cnt, r_err_cnt;

    logic             w_in_frame, w_lrc_en, w_timeout;
    logic             w_dst_ok, w_dst_bc, w_dst_accept;
    logic [15:0]      w_len;
    logic [7:0]       w_fcs_exp;

    assign w_in_frame   = (r_state != IDLE) && (r_state != DONE);
    assign w_lrc_en     = (r_state == MACDST) || (r_state == MACSRC) ||
                          (r_state == LEN)    || (r_state == PL);
    assign w_timeout    = (TIMEOUT > 0) && w_in_frame && !i_data_vld && (r_idle == TO_LAST);
    // Address flags accumulate across the six bytes; byte 0 starts them fresh.
    assign w_dst_ok     = ((r_cnt == 16'd0) || r_dst_ok) && (i_data == dest_byte(r_cnt[2:0]));
    assign w_dst_bc     = ((r_cnt == 16'd0) || r_dst_bc) && (i_data == 8'hFF);
    assign w_dst_accept = i_promisc || w_dst_ok || (ACCEPT_BCAST && w_dst_bc);
    assign w_len        = {r_len[7:0], i_data};
    assign w_fcs_exp    = ~r_lrc + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = ST_OK;
        case (r_state)
            IDLE: if (i_start) w_state_nxt = PREAMBLE;
            PREAMBLE: if (i_data_vld) begin
                if (i_data != 8'hAA) begin
                    w_state_nxt  = DONE;
                    w_status_nxt = ST_PRE;
                end else if (r_cnt == PRE_LAST) begin
                    w_state_nxt = SFD;
                end
            end
            SFD: if (i_data_vld) begin
                if (i_data != 8'hAB) begin
                    w_state_nxt  = DONE;
                    w_status_nxt = ST_SFD;
                end else begin
                    w_state_nxt = MACDST;
                end
            end
            MACDST: if (i_data_vld && r_cnt == 16'd5) begin
                if (w_dst_accept) begin
                    w_state_nxt = MACSRC;
                end else begin
                    w_state_nxt  = DONE;
                    w_status_nxt = ST_DROP;
                end
            end
            MACSRC: if (i_data_vld && r_cnt == 16'd5) w_state_nxt = LEN;
            LEN: if (i_data_vld && r_cnt == 16'd1) begin
                if (w_len == 16'd0 || w_len > MAX_LEN) begin
                    w_state_nxt  = DONE;
                    w_status_nxt = ST_LEN;
                end else begin
                    w_state_nxt = PL;
                end
            end
            PL: if (i_data_vld && r_cnt == r_len - 16'd1) w_state_nxt = FCS;
            FCS: if (i_data_vld) begin
                if (i_data != w_fcs_exp) begin
                    w_state_nxt  = DONE;
                    w_status_nxt = ST_FCS;
                end else if (r_cnt == FCS_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt  = DONE;
            w_status_nxt = ST_TO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idle       <= '0;
            r_lrc        <= '0;
            r_dst_ok     <= 1'b0;
            r_dst_bc     <= 1'b0;
            r_src_hold   <= '0;
            r_len        <= '0;
            r_pl_data_p1 <= '0;
            r_pl_vld_p1  <= 1'b0;
            r_pl_sof_p1  <= 1'b0;
            r_pl_eof_p1  <= 1'b0;
            r_src_mac    <= '0;
            r_status     <= '0;
            r_ok_cnt     <= '0;
            r_err_cnt    <= '0;
        end else begin
            if (w_state_nxt != r_state)       r_cnt <= '0;
            else if (i_data_vld && w_in_frame) r_cnt <= r_cnt + 16'd1;

            if (!w_in_frame || i_data_vld) r_idle <= '0;
            else                           r_idle <= r_idle + 1'b1;

            if (r_state == SFD)              r_lrc <= '0;
            else if (i_data_vld && w_lrc_en) r_lrc <= r_lrc + i_data;

            if (i_data_vld) begin
                case (r_state)
                    MACDST: begin
                        r_dst_ok <= w_dst_ok;
                        r_dst_bc <= w_dst_bc;
                    end
                    MACSRC:  r_src_hold <= {r_src_hold[39:0], i_data};
                    LEN:     r_len      <= w_len;
                    default: ;
                endcase
            end

            // Payload output stage: one cycle behind the accepted byte.
            r_pl_vld_p1 <= i_data_vld && (r_state == PL);
            if (i_data_vld && r_state == PL) begin
                r_pl_data_p1 <= i_data;
                r_pl_sof_p1  <= (r_cnt == 16'd0);
                r_pl_eof_p1  <= (r_cnt == r_len - 16'd1);
            end

            if (w_state_nxt == DONE && r_state != DONE) begin
                r_status <= w_status_nxt;
                if (w_status_nxt == ST_OK) r_src_mac <= r_src_hold;
            end

            // Address drops and the reserved code are deliberately not counted.
            if (r_state == DONE) begin
                if (r_status == ST_OK)
                    r_ok_cnt <= sat_inc(r_ok_cnt);
                else if (r_status != ST_DROP && r_status != 3'd7)
                    r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    assign o_ready   = (r_state == IDLE);
    assign o_done    = (r_state == DONE);
    assign o_status  = r_status;
    assign o_pl_data = r_pl_data_p1;
    assign o_pl_vld  = r_pl_vld_p1;
    assign o_pl_sof  = r_pl_vld_p1 & r_pl_sof_p1;
    assign o_pl_eof  = r_pl_vld_p1 & r_pl_eof_p1;
    assign o_src_mac = r_src_mac;
    assign o_ok_cnt  = r_ok_cnt;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_eth_frame_rx_v2.sv
// Directed bench for eth_frame_rx_v2: frames are built from a byte model, expected
// payload beats and statuses are queued with their due cycle and checked each cycle.
module tb_eth_frame_rx_v2;

    localparam logic [47:0] DEST = 48'h00_0a_95_9d_68_16;
    localparam int PRE  = 7;
    localparam int FCSL = 4;
    localparam int TO   = 255;
    localparam logic [47:0] SRC1    = 48'h11_22_33_44_55_66;
    localparam logic [47:0] SRC2    = 48'ha0_b1_c2_d3_e4_f5;
    localparam logic [47:0] SRC3    = 48'h0e_0d_0c_0b_0a_09;
    localparam logic [47:0] BCAST   = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [47:0] FOREIGN = 48'h02_00_00_00_00_01;

    logic        clk, rst;
    logic [7:0]  i_data;
    logic        i_data_vld, i_start, i_promisc;
    logic        o_ready, o_pl_vld, o_pl_sof, o_pl_eof, o_done;
    logic [7:0]  o_pl_data;
    logic [47:0] o_src_mac;
    logic [2:0]  o_status;
    logic [15:0] o_ok_cnt, o_err_cnt;

    eth_frame_rx_v2 #(
        .DEST_MAC_ADDR(DEST), .PREAMBLE_LEN(PRE), .FCS_LEN(FCSL), .MAX_PAYLOAD(1500),
        .ACCEPT_BCAST(1'b1), .TIMEOUT(TO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_data_vld(i_data_vld),
        .i_start(i_start), .i_promisc(i_promisc), .o_ready(o_ready),
        .o_pl_data(o_pl_data), .o_pl_vld(o_pl_vld), .o_pl_sof(o_pl_sof),
        .o_pl_eof(o_pl_eof), .o_src_mac(o_src_mac), .o_done(o_done),
        .o_status(o_status), .o_ok_cnt(o_ok_cnt), .o_err_cnt(o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic sof; logic eof; int due; } pl_t;
    typedef struct { logic [2:0] st; int due; } st_t;

    pl_t         exp_pl[$];
    st_t         exp_st[$];
    logic [7:0]  fq[$];
    logic [2:0]  ftag[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          got_done = 1'b0;
    int          ok_m = 0;
    int          err_m = 0;
    logic [47:0] src_m = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic monitor();
        pl_t e;
        st_t s;
        if (exp_pl.size() > 0 && exp_pl[0].due == cyc) begin
            e = exp_pl.pop_front();
            chk("pl_beat", {o_pl_vld, o_pl_sof, o_pl_eof, o_pl_data}, {1'b1, e.sof, e.eof, e.d});
        end else begin
            chk("pl_quiet", o_pl_vld, 0);
        end
        if (o_done) begin
            got_done = 1'b1;
            if (exp_st.size() == 0) begin
                chk("done_spurious", o_done, 0);
            end else begin
                s = exp_st.pop_front();
                chk("status", o_status, s.st);
                if (s.due != 0) chk("done_cycle", cyc, s.due);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_status(input logic [2:0] st, input int due);
        st_t s;
        s.st  = st;
        s.due = due;
        exp_st.push_back(s);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic [2:0] tag, inout logic [7:0] lrc,
                             input bit sum);
        fq.push_back(b);
        ftag.push_back(tag);
        if (sum) lrc = lrc + b;
    endtask

    // Builds one frame; bad_pre < 0 means a clean preamble, pl_exp marks payload as expected.
    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] len,
                         input int npl, input int bad_pre, input bit bad_fcs, input bit pl_exp);
        logic [7:0] lrc;
        logic [7:0] b;
        logic [7:0] fcs;
        fq.delete();
        ftag.delete();
        lrc = 8'd0;
        for (int i = 0; i < PRE; i++) push_byte((i == bad_pre) ? 8'hAB : 8'hAA, 3'b000, lrc, 1'b0);
        push_byte(8'hAB, 3'b000, lrc, 1'b0);
        for (int i = 0; i < 6; i++) push_byte(dst[47-8*i -: 8], 3'b000, lrc, 1'b1);
        for (int i = 0; i < 6; i++) push_byte(src[47-8*i -: 8], 3'b000, lrc, 1'b1);
        push_byte(len[15:8], 3'b000, lrc, 1'b1);
        push_byte(len[7:0], 3'b000, lrc, 1'b1);
        for (int i = 0; i < npl; i++) begin
            b = 8'((i + 1) * 17);
            push_byte(b, {pl_exp, (i == 0), (i == npl - 1)}, lrc, 1'b1);
        end
        fcs = 8'd0 - lrc;
        for (int i = 0; i < FCSL; i++)
            push_byte((bad_fcs && i == FCSL - 1) ? (fcs ^ 8'h5A) : fcs, 3'b000, lrc, 1'b0);
    endtask

    task automatic send_frame(input bit gap, input int nsend);
        pl_t e;
        int  n;
        n = (nsend < 0) ? fq.size() : nsend;
        got_done = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("ready_busy", o_ready, 0);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                i_data_vld = 1'b0;
                i_data     = 8'($urandom);
                tick();
            end
            i_data     = fq[i];
            i_data_vld = 1'b1;
            if (ftag[i][2]) begin
                e.d   = fq[i];
                e.sof = ftag[i][1];
                e.eof = ftag[i][0];
                e.due = cyc + 1;
                exp_pl.push_back(e);
            end
            tick();
            i_data_vld = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound);
        for (int k = 0; k < bound && !got_done; k++) tick();
        chk("done_seen", got_done, 1);
        got_done = 1'b0;
    endtask

    task automatic check_stats();
        chk("ok_cnt", o_ok_cnt, ok_m);
        chk("err_cnt", o_err_cnt, err_m);
        chk("src_mac", o_src_mac, src_m);
        chk("ready_idle", o_ready, 1);
        chk("queues_drained", exp_pl.size() + exp_st.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; i_data = '0; i_data_vld = 1'b0; i_start = 1'b0; i_promisc = 1'b0;
        #3;
        chk("rst_ready", o_ready, 1);
        chk("rst_outs", {o_pl_vld, o_pl_sof, o_pl_eof, o_pl_data, o_done, o_status}, 0);
        chk("rst_src", o_src_mac, 0);
        chk("rst_cnts", {o_ok_cnt, o_err_cnt}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(); tick();

        // Good unicast frame, then the same frame with stalls between bytes.
        build(DEST, SRC1, 16'd3, 3, -1, 1'b0, 1'b1);
        expect_status(3'd0, 0);
        send_frame(1'b0, -1); wait_done(20);
        ok_m = 1; src_m = SRC1; check_stats();

        build(DEST, SRC1, 16'd3, 3, -1, 1'b0, 1'b1);
        expect_status(3'd0, 0);
        send_frame(1'b1, -1); wait_done(20);
        ok_m = 2; check_stats();

        // Address filtering: broadcast, foreign drop, foreign with promiscuous mode.
        build(BCAST, SRC2, 16'd3, 3, -1, 1'b0, 1'b1);
        expect_status(3'd0, 0);
        send_frame(1'b0, -1); wait_done(20);
        ok_m = 3; src_m = SRC2; check_stats();

        build(FOREIGN, SRC3, 16'd3, 3, -1, 1'b0, 1'b0);
        expect_status(3'd3, 0);
        send_frame(1'b0, -1); wait_done(20);
        check_stats();

        i_promisc = 1'b1;
        build(FOREIGN, SRC3, 16'd3, 3, -1, 1'b0, 1'b1);
        expect_status(3'd0, 0);
        send_frame(1'b0, -1); wait_done(20);
        i_promisc = 1'b0;
        ok_m = 4; src_m = SRC3; check_stats();

        // Bad third preamble byte: done on the cycle right after it.
        build(DEST, SRC1, 16'd3, 3, 2, 1'b0, 1'b0);
        expect_status(3'd1, cyc + 4);
        send_frame(1'b0, -1); wait_done(5);
        err_m = 1; check_stats();

        build(DEST, SRC1, 16'd1501, 0, -1, 1'b0, 1'b0);
        expect_status(3'd4, 0);
        send_frame(1'b0, -1); wait_done(20);
        err_m = 2; check_stats();

        // Corrupt last FCS byte: payload still streams out.
        build(DEST, SRC2, 16'd3, 3, -1, 1'b1, 1'b1);
        expect_status(3'd5, 0);
        send_frame(1'b0, -1); wait_done(20);
        err_m = 3; check_stats();

        // Single-byte payload carries sof and eof together.
        build(DEST, SRC1, 16'd1, 1, -1, 1'b0, 1'b1);
        expect_status(3'd0, 0);
        send_frame(1'b0, -1); wait_done(20);
        ok_m = 5; src_m = SRC1; check_stats();

        // Stall after the first payload byte until the timeout fires.
        build(DEST, SRC2, 16'd3, 3, -1, 1'b0, 1'b1);
        send_frame(1'b0, PRE + 16);
        expect_status(3'd6, cyc + TO);
        wait_done(TO + 10);
        err_m = 4; check_stats();

        // Reset in the middle of the payload.
        build(DEST, SRC2, 16'd3, 3, -1, 1'b0, 1'b1);
        send_frame(1'b0, PRE + 16);
        exp_pl.delete();
        rst = 1'b1;
        #1;
        chk("midrst_ready", o_ready, 1);
        chk("midrst_cnts", {o_ok_cnt, o_err_cnt}, 0);
        chk("midrst_outs", {o_pl_vld, o_done, o_status, o_src_mac}, 0);
        #1;
        rst = 1'b0;
        ok_m = 0; err_m = 0; src_m = '0;
        @(posedge clk); #1;
        tick(); tick(); tick();

        build(DEST, SRC3, 16'd3, 3, -1, 1'b0, 1'b1);
        expect_status(3'd0, 0);
        send_frame(1'b0, -1); wait_done(20);
        ok_m = 1; src_m = SRC3; check_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
